// File: rtl/mem_8192x64_ctrl.sv
// Request/response front-end for the mem_8192x64 single-port SRAM macro.
// Issues one request per cycle and returns read data in order through a credit-guarded FIFO.
module mem_8192x64_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int MASK_W     = 8,
  parameter int RESP_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_bits_addr,
  input  logic                          req_bits_write,
  input  logic [DATA_W-1:0]             req_bits_data,
  input  logic [MASK_W-1:0]             req_bits_mask,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_W-1:0]             resp_bits_data,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_en,
  output logic                          mem_wmode,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [MASK_W-1:0]             mem_wmask,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(RESP_DEPTH):0]   outstanding
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OCC_W = $clog2(RESP_DEPTH) + 1;

  logic [DATA_W-1:0] buf_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              fire, deq, push;
  logic [OCC_W:0]    credit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    resp_valid = (occ_q != '0);
    deq        = resp_valid & resp_ready;
    // Slots still claimed once this cycle's dequeue leaves; writes are throttled the same way.
    credit     = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(deq);
    req_ready  = ~reset & (credit < (OCC_W+1)'(RESP_DEPTH));
    fire       = req_valid & req_ready;
    push       = inflight_q;

    inflight_d = fire & ~req_bits_write;
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(deq);
    wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = deq  ? next_ptr(rd_ptr_q) : rd_ptr_q;

    mem_en     = fire;
    mem_wmode  = req_bits_write;
    mem_addr   = req_bits_addr;
    mem_wdata  = req_bits_data;
    mem_wmask  = req_bits_write ? req_bits_mask : '0;

    outstanding    = occ_q + OCC_W'(inflight_q);
    resp_bits_data = buf_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is deliberately not reset; a read in flight across reset is dropped by the push gating.
  always_ff @(posedge clock) begin
    if (!reset && push) buf_q[wr_ptr_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_8192x64_ctrl.sv
// Directed self-checking bench for mem_8192x64_ctrl with a behavioural model of the SRAM macro.
module tb_mem_8192x64_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [12:0] req_bits_addr;
  logic        req_bits_write;
  logic [63:0] req_bits_data;
  logic [7:0]  req_bits_mask;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_bits_data;
  logic [12:0] mem_addr;
  logic        mem_en, mem_wmode;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;
  logic [1:0]  outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sram [8192];

  mem_8192x64_ctrl #(.ADDR_W(13), .DATA_W(64), .MASK_W(8), .RESP_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bits_addr(req_bits_addr), .req_bits_write(req_bits_write),
    .req_bits_data(req_bits_data), .req_bits_mask(req_bits_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits_data(resp_bits_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  // Macro model: masked write, one-cycle read latency, garbage on rdata when not reading.
  always @(posedge clock) begin
    if (mem_en && mem_wmode) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_wmode) mem_rdata <= sram[mem_addr];
    else                      mem_rdata <= {$urandom, $urandom};
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'hF00D_0000 | 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_bits_write = 1'b0; req_bits_addr = '0;
    req_bits_data = '0; req_bits_mask = '0;
  endtask

  task automatic drive_rd(input logic [12:0] a);
    req_valid = 1'b1; req_bits_write = 1'b0; req_bits_addr = a;
    req_bits_data = 64'hBAD0_BAD0_BAD0_BAD0; req_bits_mask = 8'hFF;
  endtask

  task automatic drive_wr(input logic [12:0] a, input logic [63:0] d, input logic [7:0] m);
    req_valid = 1'b1; req_bits_write = 1'b1; req_bits_addr = a;
    req_bits_data = d; req_bits_mask = m;
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b0;
    drive_rd(13'h000);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_mem_en", mem_en, 0);
      tick();
    end
    reset = 1'b0; drive_idle();
    @(negedge clock);
    check_eq("post_rst_valid", resp_valid, 0);
    check_eq("post_rst_outst", outstanding, 0);
    check_eq("post_rst_mem_en", mem_en, 0);
    check_eq("post_rst_ready", req_ready, 1);
    tick();

    // Single write then read
    drive_wr(13'h005, 64'h0123456789ABCDEF, 8'hFF);
    @(negedge clock);
    check_eq("wr_en", mem_en, 1);
    check_eq("wr_wmode", mem_wmode, 1);
    check_eq("wr_addr", mem_addr, 13'h005);
    check_eq("wr_wdata", mem_wdata, 64'h0123456789ABCDEF);
    check_eq("wr_wmask", mem_wmask, 8'hFF);
    tick();
    drive_rd(13'h005);
    @(negedge clock);
    check_eq("rd_en", mem_en, 1);
    check_eq("rd_wmode", mem_wmode, 0);
    check_eq("wr_no_resp", resp_valid, 0);
    check_eq("wr_no_outst", outstanding, 0);
    tick();
    drive_idle();
    @(negedge clock);
    check_eq("rd_t1_valid", resp_valid, 0);
    check_eq("rd_t1_outst", outstanding, 1);
    tick();
    @(negedge clock);
    check_eq("rd_t2_valid", resp_valid, 1);
    check_eq("rd_t2_data", resp_bits_data, 64'h0123456789ABCDEF);
    check_eq("rd_t2_outst", outstanding, 1);
    tick();
    resp_ready = 1'b1;
    @(negedge clock);
    check_eq("rd_hold_valid", resp_valid, 1);
    tick();
    resp_ready = 1'b0;
    @(negedge clock);
    check_eq("rd_drained", resp_valid, 0);
    check_eq("rd_drained_outst", outstanding, 0);
    tick();

    // Partial mask
    drive_wr(13'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick();
    drive_wr(13'h010, 64'h0, 8'h0F);
    @(negedge clock);
    check_eq("pm_wmask", mem_wmask, 8'h0F);
    tick();
    drive_rd(13'h010);
    @(negedge clock);
    check_eq("pm_rd_wmask", mem_wmask, 8'h00);
    check_eq("pm_rd_en", mem_en, 1);
    tick();
    drive_idle();
    @(negedge clock);
    check_eq("pm_t1_valid", resp_valid, 0);
    tick();
    resp_ready = 1'b1;
    @(negedge clock);
    check_eq("pm_valid", resp_valid, 1);
    check_eq("pm_data", resp_bits_data, 64'hFFFFFFFF00000000);
    tick();
    resp_ready = 1'b0;

    // Preload 16 rows for streaming/backpressure
    for (int i = 0; i < 16; i++) begin
      drive_wr(13'h100 + 13'(i), pat(i), 8'hFF);
      tick();
    end
    drive_idle();
    tick();

    // Streaming
    resp_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive_rd(13'h100 + 13'(k));
      else        drive_idle();
      @(negedge clock);
      if (k < 16) check_eq("st_ready", req_ready, 1);
      check_eq("st_outst_le2", outstanding <= 2, 1);
      if (k == 5) check_eq("st_outst_steady", outstanding, 2);
      if (k >= 2) begin
        check_eq("st_valid", resp_valid, 1);
        check_eq("st_data", resp_bits_data, pat(k - 2));
      end else begin
        check_eq("st_valid_early", resp_valid, 0);
      end
      tick();
    end
    @(negedge clock);
    check_eq("st_done", resp_valid, 0);
    tick();

    // Backpressure
    resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_rd(13'h100 + 13'((k < 2) ? k : 2));
      @(negedge clock);
      check_eq("bp_ready", req_ready, (k < 2) ? 1 : 0);
      if (k == 4) begin
        check_eq("bp_full_valid", resp_valid, 1);
        check_eq("bp_full_data", resp_bits_data, pat(0));
        check_eq("bp_full_outst", outstanding, 2);
      end
      tick();
    end
    resp_ready = 1'b1;
    drive_rd(13'h102);
    @(negedge clock);
    check_eq("bp_rel_valid", resp_valid, 1);
    check_eq("bp_rel_data", resp_bits_data, pat(0));
    check_eq("bp_rel_ready", req_ready, 1);
    check_eq("bp_rel_en", mem_en, 1);
    tick();
    drive_idle();
    @(negedge clock);
    check_eq("bp_r1_data", resp_bits_data, pat(1));
    tick();
    @(negedge clock);
    check_eq("bp_r2_valid", resp_valid, 1);
    check_eq("bp_r2_data", resp_bits_data, pat(2));
    tick();
    @(negedge clock);
    check_eq("bp_empty", resp_valid, 0);
    check_eq("bp_empty_outst", outstanding, 0);
    tick();

    // Write throttling with full FIFO
    resp_ready = 1'b0;
    drive_rd(13'h103);
    tick();
    drive_rd(13'h104);
    tick();
    drive_wr(13'h105, 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check_eq("wt_ready", req_ready, 0);
      check_eq("wt_en", mem_en, 0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clock);
    check_eq("wt_rel_en", mem_en, 1);
    check_eq("wt_rel_data", resp_bits_data, pat(3));
    tick();
    drive_idle();
    @(negedge clock);
    check_eq("wt_r1_valid", resp_valid, 1);
    check_eq("wt_r1_data", resp_bits_data, pat(4));
    tick();
    drive_rd(13'h105);
    @(negedge clock);
    check_eq("wt_nowresp", resp_valid, 0);
    tick();
    drive_idle();
    tick();
    @(negedge clock);
    check_eq("wt_rb_valid", resp_valid, 1);
    check_eq("wt_rb_data", resp_bits_data, 64'h5A5A_5A5A_A5A5_A5A5);
    tick();
    @(negedge clock);
    check_eq("wt_rb_empty", resp_valid, 0);
    tick();

    // Reset mid-operation
    resp_ready = 1'b0;
    drive_rd(13'h100);
    tick();
    reset = 1'b1;
    drive_rd(13'h101);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check_eq("mr_ready", req_ready, 0);
      check_eq("mr_en", mem_en, 0);
      tick();
    end
    reset = 1'b0;
    drive_idle();
    @(negedge clock);
    check_eq("mr_valid", resp_valid, 0);
    check_eq("mr_outst", outstanding, 0);
    check_eq("mr_mem_en", mem_en, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_eq("mr_dropped", resp_valid, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_8192x64_ctrl.md
# mem_8192x64_ctrl

Request/response front-end that sits directly upstream of the `mem_8192x64` single-port SRAM macro. It accepts decoupled read/write requests and drives the macro's RW0 port one request per cycle. It captures read data one cycle after issue into an in-order response FIFO. Credit-based backpressure ensures a read is never issued without guaranteed response storage.

## Interface
- `ADDR_W`, 13, address width; matches the macro's 8192 rows.
- `DATA_W`, 64, data width.
- `MASK_W`, 8, byte-mask width (`DATA_W/8`).
- `RESP_DEPTH`, 2, response FIFO entries; minimum 2.

- `clock` in 1: single clock, all state is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request can be accepted this cycle.
- `req_bits_addr` in `ADDR_W`: row address.
- `req_bits_write` in 1: 1 = write, 0 = read.
- `req_bits_data` in `DATA_W`: write data.
- `req_bits_mask` in `MASK_W`: byte enables; bit i covers data[8i+7:8i].
- `resp_valid` out 1: read response available.
- `resp_ready` in 1: consumer takes the response.
- `resp_bits_data` out `DATA_W`: read data.
- `mem_addr` out `ADDR_W`: to RW0_addr.
- `mem_en` out 1: to RW0_en.
- `mem_wmode` out 1: to RW0_wmode.
- `mem_wdata` out `DATA_W`: to RW0_wdata.
- `mem_wmask` out `MASK_W`: to RW0_wmask.
- `mem_rdata` in `DATA_W`: from RW0_rdata.
- `outstanding` out `clog2(RESP_DEPTH)+1`: current FIFO occupancy plus the in-flight read count.

## Operation
- **Fire:** `fire = req_valid & req_ready`.
- **Deq:** `deq = resp_valid & resp_ready`.
- **SRAM drive:**
  - `mem_en = fire`.
  - `mem_wmode = req_bits_write`.
  - `mem_addr` and `mem_wdata` pass through from the request fields.
  - `mem_wmask = req_bits_write ? req_bits_mask : 0`.
  - All of these are combinational from the request inputs.
- **Writes:**
  - Complete at issue.
  - Produce no response.
  - Consume no credit.
- **Reads:**
  - When a read fires, set the `inflight` flag (1 bit) for the next cycle.
  - In the cycle where `inflight` is 1, `mem_rdata` is valid. It is pushed into the FIFO at the end of that cycle.
  - `mem_rdata` is ignored when `inflight` is 0, including X values.
- **Response FIFO:**
  - Circular buffer with `RESP_DEPTH` entries, a write pointer, a read pointer, and an occupancy counter `occ`.
  - Pointers wrap modulo `RESP_DEPTH`.
  - Responses are delivered strictly in request order.
  - `resp_valid = (occ != 0)`.
  - `resp_bits_data` is the entry at the read pointer; it is registered and has no bypass path.
- **Credit / ready:**
  - `req_ready = ~reset & ((occ + inflight - deq) < RESP_DEPTH)`.
  - Ready does not depend on `req_bits_*`, so writes are throttled exactly like reads.
  - `outstanding = occ + inflight`.
- **Simultaneous push and deq:** `occ` is unchanged and both pointers advance. Push never targets a full FIFO; the credit rule guarantees this.
- **Read-after-write hazards:** no hazard or forwarding logic. Ordering relies on the macro's one-request-per-cycle semantics.
- **Reset:**
  - Clears `occ`, both pointers, and `inflight`.
  - An in-flight read at reset is dropped and its data discarded.
  - FIFO data storage is not reset.

## Timing
- Read accepted in cycle t:
  - `mem_en=1, mem_wmode=0` in cycle t.
  - `mem_rdata` sampled at end of t+1.
  - `resp_valid=1` in t+2.
  - Read-to-response latency is 2 cycles.
- Write accepted in cycle t: `mem_en=1, mem_wmode=1` in cycle t only.
- Throughput: with `resp_ready` held high, one read per cycle is sustained at `RESP_DEPTH=2`. In steady state `occ=1`, `inflight=1`, `deq=1`.
- Stall: with `resp_ready=0`, at most `RESP_DEPTH` reads are accepted. `req_ready` drops in the cycle where `occ + inflight == RESP_DEPTH`.
- Outputs during and immediately after reset:
  - `req_ready=0` while `reset=1`.
  - In the first cycle after reset: `resp_valid=0`, `outstanding=0`, `mem_en=0`.

## Test plan
- **Single read/write:** write addr 0x005, data 0x0123456789ABCDEF, mask 0xFF; then read 0x005 → `resp_valid` 2 cycles after the read fires, data 0x0123456789ABCDEF; no response for the write.
- **Partial mask:** write 0xFFFF…FF mask 0xFF to addr 0x010, then 0x0 mask 0x0F, then read 0x010 → 0xFFFFFFFF00000000; `mem_wmask` is 0 on the read cycle.
- **Streaming:** with `resp_ready=1`, issue 16 back-to-back reads → `req_ready` stays 1, 16 in-order responses on consecutive cycles, `outstanding ≤ 2` throughout.
- **Backpressure:** with `resp_ready=0`, offer reads continuously → exactly 2 fire, `req_ready=0` from the 3rd cycle on; raise `resp_ready` → first response dequeued and `req_ready` returns 1 in that same cycle; no data lost or reordered.
- **Write throttling:** with the FIFO full and `resp_ready=0`, offer a write → not accepted (`mem_en=0`) until a response dequeues.
- **Reset mid-operation:** assert `reset` one cycle after a read fires → after release `resp_valid=0` and `outstanding=0`; the dropped read never appears; `req_ready` is 0 during reset.
